// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the CPU fetch (I) and data (D) ports.
// D has priority, a D-grant streak limit guarantees fetch progress, and a watchdog turns a lost
// mem_done into an error completion.
module mem_port_arbiter #(
   parameter int unsigned DW           = 32,
   parameter int unsigned AW           = 32,
   parameter int unsigned MAX_D_STREAK = 4,
   parameter int unsigned TIMEOUT      = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req,
   input  logic [AW-1:0] i_addr,
   output logic [DW-1:0] i_rdata,
   output logic          i_done,
   output logic          i_err,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_done,
   output logic          d_err,
   output logic          mem_r,
   output logic          mem_w,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_done
);

   localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
   localparam int unsigned WW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e          state_q;
   logic            sel_d_q;
   logic            we_q;
   logic [SW-1:0]   streak_q;
   logic [SW-1:0]   streak_d;
   logic [WW-1:0]   wdog_q;
   logic            mem_r_q;
   logic            mem_w_q;
   logic [AW-1:0]   addr_q;
   logic [DW-1:0]   wdata_q;
   logic [DW-1:0]   i_rdata_q;
   logic [DW-1:0]   d_rdata_q;
   logic            i_done_q;
   logic            i_err_q;
   logic            d_done_q;
   logic            d_err_q;

   logic            grant_d_c;
   logic            wdog_exp_c;

   // D wins unless it has used up its streak while a fetch is waiting
   assign grant_d_c  = d_req & (~i_req | (streak_q != SW'(MAX_D_STREAK)));
   assign wdog_exp_c = (wdog_q == WW'(TIMEOUT - 1));

   // Streak after a grant: saturating count of D grants that made a pending fetch wait
   always_comb begin
      streak_d = '0;
      if (grant_d_c && i_req) begin
         streak_d = (streak_q == SW'(MAX_D_STREAK)) ? streak_q : streak_q + SW'(1);
      end
   end

   // Arbitration FSM with all outputs registered; done/err are single-cycle pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         sel_d_q   <= 1'b0;
         we_q      <= 1'b0;
         streak_q  <= '0;
         wdog_q    <= '0;
         mem_r_q   <= 1'b0;
         mem_w_q   <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
         i_done_q  <= 1'b0;
         i_err_q   <= 1'b0;
         d_done_q  <= 1'b0;
         d_err_q   <= 1'b0;
      end else begin
         i_done_q <= 1'b0;
         i_err_q  <= 1'b0;
         d_done_q <= 1'b0;
         d_err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_req || d_req) begin
                  sel_d_q  <= grant_d_c;
                  we_q     <= grant_d_c & d_we;
                  addr_q   <= grant_d_c ? d_addr : i_addr;
                  wdata_q  <= grant_d_c ? d_wdata : '0;
                  mem_r_q  <= ~(grant_d_c & d_we);
                  mem_w_q  <= grant_d_c & d_we;
                  streak_q <= streak_d;
                  wdog_q   <= '0;
                  state_q  <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               wdog_q <= wdog_q + WW'(1);
               // mem_done on the expiry cycle still counts as success
               if (mem_done || wdog_exp_c) begin
                  mem_r_q <= 1'b0;
                  mem_w_q <= 1'b0;
                  state_q <= ST_RESP;
                  if (sel_d_q) begin
                     d_done_q <= 1'b1;
                     d_err_q  <= ~mem_done;
                     if (mem_done && !we_q) begin
                        d_rdata_q <= mem_rdata;
                     end
                  end else begin
                     i_done_q <= 1'b1;
                     i_err_q  <= ~mem_done;
                     if (mem_done) begin
                        i_rdata_q <= mem_rdata;
                     end
                  end
               end
            end
            ST_RESP: begin
               wdog_q  <= '0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_r     = mem_r_q;
   assign mem_w     = mem_w_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign i_rdata   = i_rdata_q;
   assign i_done    = i_done_q;
   assign i_err     = i_err_q;
   assign d_rdata   = d_rdata_q;
   assign d_done    = d_done_q;
   assign d_err     = d_err_q;

endmodule
